systolic_matmul_nxn: RTL and testbench
======================================

Name: systolic_matmul_nxn

Overview:
- Parametrised output-stationary N×N systolic matrix multiplier: computes C = A·B for square N×N matrices.
- Successor to the fixed 2x2 array. Adds per-lane input skew, a start/busy/done controller, valid/ready input streaming with bubbles, and row-serial result readout with backpressure.
- Sits between an operand streamer (DMA/scratchpad) and the result writeback path of the GPU tensor unit.

Parameters:
- N, 4, array dimension; N >= 2.
- DATA_W, 8, operand width.
- ACC_W, 2*DATA_W+$clog2(N), accumulator/result width.
- SIGNED, 0, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new job; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last result row is accepted.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- a_col  in  N*DATA_W  column k of A; lane i = A[i][k]; lane 0 in the LSBs.
- b_row  in  N*DATA_W  row k of B; lane j = B[k][j]; lane 0 in the LSBs.
- out_valid  out  1  result row valid.
- out_ready  in  1  result row accepted.
- out_row  out  N*ACC_W  lane j = C[r][j]; lane 0 in the LSBs.
- out_row_idx  out  $clog2(N)  row index r of out_row.

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE, all counters 0, accumulators 0, skew/PE pipeline registers 0.
  - in_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0.
  - Reset mid-operation abandons the job with no residue.
- FSM states: IDLE → LOAD → DRAIN → OUTPUT → IDLE.
  - IDLE: start=1 → clear all accumulators on that edge, enter LOAD.
  - LOAD: in_ready=1. A beat is accepted when in_valid&in_ready. A beat counter counts accepted beats; after beat N-1 is accepted, enter DRAIN.
  - DRAIN: fixed 2N-1 cycles (counter), then enter OUTPUT.
  - OUTPUT: out_valid=1, out_row = accumulator row r, out_row_idx = r, starting at r=0. Advance r on out_valid&out_ready. After row N-1 is accepted: done=1 for one cycle, enter IDLE.
- start outside IDLE is ignored.
- Input skew:
  - Row lane i of A passes through i registers; column lane j of B passes through j registers.
  - PE(i,j) forwards a right and b down, one register per hop.
- The array shifts every cycle in LOAD and DRAIN.
  - A cycle with no accepted beat injects zeros at all lanes.
  - A bubble therefore pairs zero with zero and contributes nothing to any sum.
  - Gaps between beats never change the result.
- Timing: the operand pair from the beat accepted at edge e accumulates in PE(i,j) at edge e+i+j+1. The final accumulation is complete at the end of DRAIN.
- Arithmetic:
  - product = a*b, width 2*DATA_W, signed or unsigned per SIGNED.
  - The product is sign- or zero-extended to ACC_W and accumulated modulo 2^ACC_W.
  - With the default ACC_W, overflow cannot occur.
- Latency without bubbles and with out_ready=1: first out_valid appears 3N-1 cycles after the start edge. Example N=4: 11 cycles.
- out_row and out_row_idx stay stable while out_valid=1 and out_ready=0.
- Accumulators hold their values in IDLE until the next start.
- out_row is don't-care-free: it drives 0 when out_valid=0.

Decomposition:
- Package systolic_pkg holds:
  - the state enum (IDLE, LOAD, DRAIN, OUTPUT).
  - the ACC_W derivation helper function.
  - the lane-slice width constants.
- Sub-module systolic_pe holds:
  - one MAC with operand registers a_out/b_out.
  - the clear input (from start) and the enable input.
  - SIGNED and width parameters.
- The top level holds the skew chains, the N×N generate grid, the FSM/counters and the output mux.

Test Plan:
1. N=2, A=[1 2;3 4], B=[5 6;7 8], back-to-back beats, out_ready=1 → rows {19,22} idx0 and {43,50} idx1, then done pulse, busy falls.
2. N=4, A=identity, B[i][j]=4i+j+1 → out_row r = B row r, i.e. row 0 = {1,2,3,4}. First out_valid arrives exactly 11 cycles after start.
3. N=4, same operands as scenario 2 with in_valid dropped for 3 cycles between every beat → identical results; DRAIN still 7 cycles after the last beat.
4. N=4, out_ready low for 5 cycles while out_row_idx=1 → out_row and out_row_idx held constant; no row skipped or duplicated; done only after row 3.
5. N=4, SIGNED=1, all A=-128, all B=127 → every C = -65024 (ACC_W=18, no wrap).
6. Reset asserted mid-LOAD after 2 beats, then a new start with the scenario 2 data → correct results with no residue. A start pulse during LOAD/OUTPUT is ignored.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the N x N output-stationary systolic multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 8;

  // Full-precision accumulator width: product bits plus growth from N terms.
  function automatic int calc_acc_w(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  localparam int DEF_ACC_W  = calc_acc_w(DEF_DATA_W, DEF_N);
  localparam int DEF_A_W    = DEF_N * DEF_DATA_W;
  localparam int DEF_ROW_W  = DEF_N * DEF_ACC_W;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: registers the incoming operand pair, forwards it right/down,
// and accumulates the registered product one cycle later.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic [DATA_W-1:0]   a_q, b_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;

  always_comb begin
    if (SIGNED != 0) begin
      prod     = $signed(a_q) * $signed(b_q);
      prod_ext = ACC_W'($signed(prod));
    end else begin
      prod     = a_q * b_q;
      prod_ext = ACC_W'(prod);
    end
    acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// Output-stationary N x N systolic C = A*B: skewed operand lanes feed a PE grid, a small
// FSM sequences LOAD/DRAIN, and finished rows are read out one per out_valid&out_ready.
module systolic_matmul_nxn
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = calc_acc_w(DATA_W, N),
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DATA_W-1:0]  a_col,
  input  logic [N*DATA_W-1:0]  b_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*ACC_W-1:0]   out_row,
  output logic [$clog2(N)-1:0] out_row_idx
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(2 * N);

  state_e         state_q, state_d;
  logic [IW-1:0]  beat_q, beat_d;
  logic [IW-1:0]  row_q, row_d;
  logic [CW-1:0]  drain_q, drain_d;
  logic           done_q, done_d;
  logic           beat_acc, shift_en, clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        beat_d  = '0;
        row_d   = '0;
        drain_d = '0;
      end
      LOAD: if (in_valid) begin
        if (beat_q == IW'(N - 1)) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + IW'(1);
        end
      end
      // Last operand pair reaches PE(N-1,N-1) 2N-1 edges after the final beat.
      DRAIN: if (drain_q == CW'(2 * N - 2)) begin
        state_d = OUTPUT;
        drain_d = '0;
      end else begin
        drain_d = drain_q + CW'(1);
      end
      OUTPUT: if (out_ready) begin
        if (row_q == IW'(N - 1)) begin
          state_d = IDLE;
          row_d   = '0;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == OUTPUT);
    busy      = (state_q != IDLE);
    done      = done_q;
    beat_acc  = in_valid && (state_q == LOAD);
    shift_en  = (state_q == LOAD) || (state_q == DRAIN);
    clr       = (state_q == IDLE) && start;
  end

  logic [DATA_W-1:0] a_lane [N];
  logic [DATA_W-1:0] b_lane [N];

  // Idle cycles inject zero on both operands so a bubble adds nothing to any sum.
  for (genvar l = 0; l < N; l++) begin : g_skew
    logic [DATA_W-1:0] a_inj, b_inj;
    assign a_inj = beat_acc ? a_col[l*DATA_W +: DATA_W] : '0;
    assign b_inj = beat_acc ? b_row[l*DATA_W +: DATA_W] : '0;
    if (l == 0) begin : g_direct
      assign a_lane[l] = a_inj;
      assign b_lane[l] = b_inj;
    end else begin : g_delay
      logic [l*DATA_W-1:0] a_sr_q, b_sr_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sr_q <= '0;
          b_sr_q <= '0;
        end else if (clr) begin
          a_sr_q <= '0;
          b_sr_q <= '0;
        end else if (shift_en) begin
          a_sr_q <= (l*DATA_W)'({a_sr_q, a_inj});
          b_sr_q <= (l*DATA_W)'({b_sr_q, b_inj});
        end
      end
      assign a_lane[l] = a_sr_q[l*DATA_W-1 -: DATA_W];
      assign b_lane[l] = b_sr_q[l*DATA_W-1 -: DATA_W];
    end
  end

  logic [DATA_W-1:0] a_fwd [N][N-1];
  logic [DATA_W-1:0] b_fwd [N-1][N];
  logic [DATA_W-1:0] a_edge_unused [N];
  logic [DATA_W-1:0] b_edge_unused [N];
  logic [ACC_W-1:0]  acc [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_in, b_in, a_out, b_out;
      if (j == 0) begin : g_a_src
        assign a_in = a_lane[i];
      end else begin : g_a_fwd
        assign a_in = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_src
        assign b_in = b_lane[j];
      end else begin : g_b_fwd
        assign b_in = b_fwd[i-1][j];
      end
      if (j < N - 1) begin : g_a_out
        assign a_fwd[i][j] = a_out;
      end else begin : g_a_edge
        assign a_edge_unused[i] = a_out;
      end
      if (i < N - 1) begin : g_b_out
        assign b_fwd[i][j] = b_out;
      end else begin : g_b_edge
        assign b_edge_unused[j] = b_out;
      end

      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (shift_en),
        .a_i   (a_in),
        .b_i   (b_in),
        .a_o   (a_out),
        .b_o   (b_out),
        .acc_o (acc[i][j])
      );
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == OUTPUT) begin
      for (int j = 0; j < N; j++) begin
        out_row[j*ACC_W +: ACC_W] = acc[row_q][j];
      end
    end
  end

  assign out_row_idx = row_q;

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Scoreboard bench: one N=2 unsigned array plus unsigned and signed N=4 arrays sharing stimulus.
module tb_systolic_matmul_nxn;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  // N=4 pair (unsigned _u, signed _s) driven by the same inputs
  logic          start4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b1;
  logic [31:0]   a_col4 = '0, b_row4 = '0;
  logic          busy_u, done_u, in_ready_u, out_valid_u;
  logic          busy_s, done_s, in_ready_s, out_valid_s;
  logic [71:0]   row_u, row_s;
  logic [1:0]    idx_u, idx_s;

  // N=2 unsigned
  logic          start2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [15:0]   a_col2 = '0, b_row2 = '0;
  logic          busy2, done2, in_ready2, out_valid2;
  logic [33:0]   row2;
  logic [0:0]    idx2;

  systolic_matmul_nxn #(.N(4), .DATA_W(DW), .SIGNED(0)) u_dut4u (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy_u), .done(done_u),
    .in_valid(in_valid4), .in_ready(in_ready_u), .a_col(a_col4), .b_row(b_row4),
    .out_valid(out_valid_u), .out_ready(out_ready4), .out_row(row_u), .out_row_idx(idx_u));

  systolic_matmul_nxn #(.N(4), .DATA_W(DW), .SIGNED(1)) u_dut4s (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy_s), .done(done_s),
    .in_valid(in_valid4), .in_ready(in_ready_s), .a_col(a_col4), .b_row(b_row4),
    .out_valid(out_valid_s), .out_ready(out_ready4), .out_row(row_s), .out_row_idx(idx_s));

  systolic_matmul_nxn #(.N(2), .DATA_W(DW), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .in_valid(in_valid2), .in_ready(in_ready2), .a_col(a_col2), .b_row(b_row2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_row(row2), .out_row_idx(idx2));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [1:0] idx; logic [71:0] ru; logic [71:0] rs; bit last; } exp4_t;
  typedef struct { logic [0:0] idx; logic [33:0] r; bit last; } exp2_t;
  exp4_t q4[$];
  exp2_t q2[$];

  function automatic logic [71:0] row4(input int c0, input int c1, input int c2, input int c3);
    return {18'(c3), 18'(c2), 18'(c1), 18'(c0)};
  endfunction

  bit first_pending = 1'b0, lat_start_chk = 1'b0, exp_done4 = 1'b0, exp_done2 = 1'b0;
  int start_cyc = 0, last_beat_cyc = 0;

  always @(negedge clk) begin
    #2;
    if (exp_done4) begin
      chk("done4_u", done_u, 1);
      chk("done4_s", done_s, 1);
      chk("busy4_after_done", busy_u, 0);
      exp_done4 = 1'b0;
    end
    if (out_valid_u) begin
      if (first_pending) begin
        first_pending = 1'b0;
        chk("drain_latency", cyc - last_beat_cyc, 7);
        if (lat_start_chk) chk("start_latency", cyc - start_cyc, 11);
      end
      if (q4.size() == 0) begin
        chk("row4_unexpected", out_valid_u, 0);
      end else begin
        chk("row4_u", row_u, q4[0].ru);
        chk("row4_s", row_s, q4[0].rs);
        chk("idx4_u", idx_u, q4[0].idx);
        chk("idx4_s", idx_s, q4[0].idx);
        chk("done4_low", done_u, 0);
        if (out_ready4) begin
          if (q4[0].last) exp_done4 = 1'b1;
          void'(q4.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (exp_done2) begin
      chk("done2", done2, 1);
      chk("busy2_after_done", busy2, 0);
      exp_done2 = 1'b0;
    end
    if (out_valid2) begin
      if (q2.size() == 0) begin
        chk("row2_unexpected", out_valid2, 0);
      end else begin
        chk("row2", row2, q2[0].r);
        chk("idx2", idx2, q2[0].idx);
        if (out_ready2) begin
          if (q2[0].last) exp_done2 = 1'b1;
          void'(q2.pop_front());
        end
      end
    end
  end

  logic [7:0] am [4][4];
  logic [7:0] bm [4][4];

  task automatic set_beat4(input int k);
    for (int i = 0; i < 4; i++) begin
      a_col4[i*8 +: 8] = am[i][k];
      b_row4[i*8 +: 8] = bm[k][i];
    end
  endtask

  task automatic run4(input int gap, input bit glitch_load, input int stall_row, input bit glitch_out);
    int t;
    int stalls;
    lat_start_chk = (gap == 0) && !glitch_load;
    @(negedge clk);
    start4 = 1'b1;
    set_beat4(0);
    in_valid4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      set_beat4(k);
      in_valid4 = 1'b1;
      t = 0;
      while (!in_ready_u && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready_wait", (t < 20), 1);
      @(negedge clk);
      in_valid4 = 1'b0;
      if (k < 3) begin
        if (glitch_load && k == 1) begin
          start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
        end
        repeat (gap) @(negedge clk);
      end
    end
    last_beat_cyc = cyc;
    first_pending = 1'b1;
    t = 0;
    stalls = 0;
    while (!done_u && t < 100) begin
      if (out_valid_u && int'(idx_u) == stall_row && stalls < 5) begin
        out_ready4 = 1'b0;
        stalls++;
        start4 = glitch_out && (stalls == 1);
      end else begin
        out_ready4 = 1'b1;
        start4 = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    out_ready4 = 1'b1;
    start4 = 1'b0;
    chk("out_phase_timeout", (t < 100), 1);
  endtask

  task automatic load_ident();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = (i == j) ? 8'd1 : 8'd0;
        bm[i][j] = 8'(4 * i + j + 1);
      end
  endtask

  // Identity * B returns B: row r = {4r+1, 4r+2, 4r+3, 4r+4}
  task automatic push_ident();
    for (int r = 0; r < 4; r++) begin
      exp4_t e;
      e.idx  = 2'(r);
      e.ru   = row4(4*r + 1, 4*r + 2, 4*r + 3, 4*r + 4);
      e.rs   = e.ru;
      e.last = (r == 3);
      q4.push_back(e);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready_u, 0);
    chk({tag, "_out_valid"}, out_valid_u, 0);
    chk({tag, "_out_row"}, row_u, 0);
    chk({tag, "_idx"}, idx_u, 0);
    chk({tag, "_busy"}, busy_u, 0);
    chk({tag, "_done"}, done_u, 0);
    chk({tag, "_busy_s"}, busy_s, 0);
    chk({tag, "_out_row_s"}, row_s, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a2 [2];
    logic [15:0] b2 [2];
    int t;
    exp2_t e2;
    exp4_t e4;

    #2;
    chk_reset_state("reset");
    chk("reset_busy2", busy2, 0);
    chk("reset_in_ready2", in_ready2, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // N=2: [1 2;3 4] * [5 6;7 8] = [19 22;43 50]
    a2[0] = {8'd3, 8'd1};
    a2[1] = {8'd4, 8'd2};
    b2[0] = {8'd6, 8'd5};
    b2[1] = {8'd8, 8'd7};
    e2.idx = 1'b0; e2.r = {17'd22, 17'd19}; e2.last = 1'b0; q2.push_back(e2);
    e2.idx = 1'b1; e2.r = {17'd50, 17'd43}; e2.last = 1'b1; q2.push_back(e2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_col2 = a2[k];
      b_row2 = b2[k];
      in_valid2 = 1'b1;
      t = 0;
      while (!in_ready2 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready2_wait", (t < 20), 1);
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    t = 0;
    while (!done2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("n2_timeout", (t < 100), 1);
    @(negedge clk);

    load_ident();
    push_ident();
    run4(0, 1'b0, -1, 1'b0);

    push_ident();
    run4(3, 1'b1, -1, 1'b0);

    push_ident();
    run4(0, 1'b0, 1, 1'b1);

    // All A = 0x80, all B = 127: unsigned 4*128*127, signed 4*(-128)*127
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = 8'h80;
        bm[i][j] = 8'd127;
      end
    for (int r = 0; r < 4; r++) begin
      e4.idx  = 2'(r);
      e4.ru   = row4(65024, 65024, 65024, 65024);
      e4.rs   = row4(-65024, -65024, -65024, -65024);
      e4.last = (r == 3);
      q4.push_back(e4);
    end
    run4(0, 1'b0, -1, 1'b0);

    // Abandon a job after two beats with a big-valued operand set still in flight
    @(negedge clk);
    start4 = 1'b1;
    in_valid4 = 1'b1;
    set_beat4(0);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    set_beat4(1);
    @(negedge clk);
    in_valid4 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midload_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load_ident();
    push_ident();
    run4(0, 1'b0, -1, 1'b0);

    repeat (5) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("idle_busy_final", busy_u, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
